// File: rtl/hsiao_pkg.sv
// Shared constants, FSM encoding and helper functions for the Hsiao SEC-DED (13,8) code.
// Codeword layout is {check[4:0], data[7:0]}.
package hsiao_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CHECK_W   = 5;
  localparam int unsigned CW_W      = DATA_W + CHECK_W;

  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned DATA_MSB  = DATA_W - 1;
  localparam int unsigned CHECK_LSB = DATA_W;
  localparam int unsigned CHECK_MSB = CW_W - 1;

  // H_COL[i] is the parity-check column of data bit d<i>.
  localparam logic [DATA_W-1:0][CHECK_W-1:0] H_COL = {
    5'b11001, 5'b10110, 5'b10101, 5'b10011,
    5'b01110, 5'b01101, 5'b01011, 5'b00111
  };

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StChk,
    StWb,
    StNext
  } scrub_state_e;

  function automatic logic [CHECK_W-1:0] hsiao_encode(input logic [DATA_W-1:0] data);
    logic [CHECK_W-1:0] chk;
    chk = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) chk = chk ^ H_COL[i];
    end
    return chk;
  endfunction

  function automatic logic [CHECK_W-1:0] hsiao_syndrome(input logic [CW_W-1:0] cw);
    return hsiao_encode(cw[DATA_MSB:DATA_LSB]) ^ cw[CHECK_MSB:CHECK_LSB];
  endfunction

endpackage

// File: rtl/hsiao_sec_ded_decoder.sv
// Combinational Hsiao SEC-DED decoder: classifies a codeword and produces the corrected word.
// The corrected codeword always carries freshly regenerated check bits.
module hsiao_sec_ded_decoder
  import hsiao_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [CW_W-1:0] cw_o,
  output logic            correctable_o,
  output logic            uncorrectable_o
);

  logic [CHECK_W-1:0] syn;
  logic [DATA_W-1:0]  flip;
  logic [DATA_W-1:0]  data_fix;
  logic               syn_nz;
  logic               syn_w1;

  always_comb begin
    syn    = hsiao_syndrome(cw_i);
    syn_nz = |syn;
    syn_w1 = ($countones(syn) == 1);
    flip   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      flip[i] = (syn == H_COL[i]);
    end
    data_fix        = cw_i[DATA_MSB:DATA_LSB] ^ flip;
    cw_o            = {hsiao_encode(data_fix), data_fix};
    // A weight-1 syndrome is a check-bit error; any other unmatched syndrome is a double.
    correctable_o   = syn_nz && ((|flip) || syn_w1);
    uncorrectable_o = syn_nz && !((|flip) || syn_w1);
  end

endmodule

// File: rtl/hsiao_memory_scrubber.sv
// Background scrubber: walks every address over an arbitrated port, decodes each word and
// rewrites single-bit errors with the corrected codeword; counts corrected and uncorrectable words.
module hsiao_memory_scrubber
  import hsiao_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [CW_W-1:0]   mem_rd_cw,
  output logic              mem_wr_en,
  output logic [CW_W-1:0]   mem_wr_cw,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] last_err_addr
);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              req_q, req_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [CW_W-1:0]   wr_cw_q, wr_cw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;
  logic [ADDR_W-1:0] last_q, last_d;

  logic [CW_W-1:0]   dec_cw;
  logic              dec_corr;
  logic              dec_uncorr;

  hsiao_sec_ded_decoder u_decoder (
    .cw_i            (mem_rd_cw),
    .cw_o            (dec_cw),
    .correctable_o   (dec_corr),
    .uncorrectable_o (dec_uncorr)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_cw_d  = wr_cw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    last_d   = last_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          busy_d  = 1'b1;
        end
      end
      StReq: begin
        if (mem_gnt) state_d = StRd;
      end
      StRd: begin
        state_d = mem_gnt ? StChk : StReq;
      end
      StChk: begin
        if (!mem_gnt) begin
          state_d = StReq;
        end else if (dec_corr) begin
          state_d = StWb;
          wr_cw_d = dec_cw;
        end else begin
          state_d = StNext;
          if (dec_uncorr) begin
            uncorr_d = (uncorr_q == '1) ? uncorr_q : uncorr_q + 1'b1;
            last_d   = ptr_q;
          end
        end
      end
      StWb: begin
        // The correction is only counted once the write-back actually lands.
        if (!mem_gnt) begin
          state_d = StReq;
        end else begin
          state_d = StNext;
          corr_d  = (corr_q == '1) ? corr_q : corr_q + 1'b1;
          last_d  = ptr_q;
        end
      end
      StNext: begin
        if ((ptr_q == '1) || abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end else begin
          state_d = StReq;
          ptr_d   = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    req_d   = (state_d == StReq) || (state_d == StRd) || (state_d == StChk) || (state_d == StWb);
    rd_en_d = (state_d == StRd);
    wr_en_d = (state_d == StWb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      req_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_cw_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      req_q    <= req_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      wr_cw_q  <= wr_cw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      last_q   <= last_d;
    end
  end

  // Strobes are qualified by the live grant so a pre-empted cycle never touches the array.
  assign mem_req       = req_q;
  assign mem_addr      = ptr_q;
  assign mem_rd_en     = rd_en_q & mem_gnt;
  assign mem_wr_en     = wr_en_q & mem_gnt;
  assign mem_wr_cw     = wr_cw_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign corr_cnt      = corr_q;
  assign uncorr_cnt    = uncorr_q;
  assign last_err_addr = last_q;

endmodule
